// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC unit: next-PC source encoding and defaults.
package pc_pkg;

    // Source of the next fetch PC, in no particular priority order
    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_BRANCH,
        NPC_RAS,
        NPC_TRAP,
        NPC_MRET
    } npc_sel_e;

    localparam int unsigned DEFAULT_PC_WIDTH = 32;
    localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

    // A fetch target is legal only when word aligned
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A pop is applied before a push in the same
// cycle; pushing into a full stack overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    top_idx;
    logic             pop_eff;
    logic [PW-1:0]    ptr_after_pop;
    logic [CW-1:0]    cnt_after_pop;
    logic [PW-1:0]    ptr_next;
    logic [CW-1:0]    cnt_next;

    assign top_idx = wr_ptr - 1'b1;
    assign top     = mem[top_idx];

    // Pop (ignored when empty) first, then push on top of the popped state
    always_comb begin
        pop_eff       = pop && (count != '0);
        ptr_after_pop = pop_eff ? (wr_ptr - 1'b1) : wr_ptr;
        cnt_after_pop = pop_eff ? (count - 1'b1) : count;
        ptr_next      = ptr_after_pop;
        cnt_next      = cnt_after_pop;
        if (push) begin
            ptr_next = ptr_after_pop + 1'b1;
            if (cnt_after_pop != CW'(DEPTH)) begin
                cnt_next = cnt_after_pop + 1'b1;
            end
        end
    end

    // Pointer and occupancy; stale entries are masked by count after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= ptr_next;
            count  <= cnt_next;
        end
    end

    // Entry storage, written at the post-pop slot
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_after_pop] <= push_data;
        end
    end

endmodule

// File: rtl/pc_ctrl_ras.sv
// Fetch PC unit: priority next-PC select (trap, mret, RAS return, redirect,
// sequential), misaligned-target trapping and a return-address stack.
module pc_ctrl_ras
    import pc_pkg::*;
#(
    parameter int unsigned          PC_WIDTH  = DEFAULT_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
    parameter logic [PC_WIDTH-1:0]  TRAP_VEC  = PC_WIDTH'(DEFAULT_TRAP_VEC),
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           go,
    input  logic                           trap,
    input  logic                           mret,
    input  logic                           branch_taken,
    input  logic                           call,
    input  logic                           ret,
    input  logic [PC_WIDTH-1:0]            branch_target,
    output logic [PC_WIDTH-1:0]            PC,
    output logic [PC_WIDTH-1:0]            epc,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_hit,
    output logic                           misaligned
);

    npc_sel_e            sel;
    logic                mis_d;
    logic                ras_push;
    logic                ras_pop;
    logic [PC_WIDTH-1:0] ras_top;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] npc;

    assign pc_plus4 = PC + PC_WIDTH'(4);

    // Priority select; a misaligned redirect becomes a trap with no RAS activity
    always_comb begin
        sel      = NPC_SEQ;
        mis_d    = 1'b0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (trap) begin
            sel = NPC_TRAP;
        end else if (mret) begin
            sel = NPC_MRET;
        end else if (ret && (ras_count != '0)) begin
            sel      = NPC_RAS;
            ras_pop  = go;
            ras_push = go && call;
        end else if (ret || call || branch_taken) begin
            if (is_misaligned(branch_target[1:0])) begin
                sel   = NPC_TRAP;
                mis_d = 1'b1;
            end else begin
                sel      = NPC_BRANCH;
                ras_pop  = go && ret;
                ras_push = go && call;
            end
        end
    end

    // Next-PC data mux driven by the selected source
    always_comb begin
        npc = pc_plus4;
        case (sel)
            NPC_SEQ:    npc = pc_plus4;
            NPC_BRANCH: npc = branch_target;
            NPC_RAS:    npc = ras_top;
            NPC_TRAP:   npc = TRAP_VEC;
            NPC_MRET:   npc = epc;
            default:    npc = pc_plus4;
        endcase
    end

    // Architectural PC/epc and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PC         <= RESET_PC;
            epc        <= '0;
            ras_hit    <= 1'b0;
            misaligned <= 1'b0;
        end else if (go) begin
            PC         <= npc;
            if (sel == NPC_TRAP) begin
                epc <= PC;
            end
            ras_hit    <= (sel == NPC_RAS);
            misaligned <= mis_d;
        end else begin
            ras_hit    <= 1'b0;
            misaligned <= 1'b0;
        end
    end

    ras_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .count     (ras_count)
    );

endmodule

// File: tb/tb_pc_ctrl_ras.sv
// Bench for pc_ctrl_ras: directed scenarios plus randomized traffic, checked
// cycle by cycle against a queue-based reference model.
module tb_pc_ctrl_ras;

    logic        clk = 1'b0;
    logic        rst_n, go, trap, mret, branch_taken, call, ret;
    logic [31:0] branch_target;
    logic [31:0] PC, epc;
    logic [2:0]  ras_count;
    logic        ras_hit, misaligned;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_pc, m_epc;
    logic        m_hit, m_mis;
    logic [31:0] m_ras[$];

    localparam logic [31:0] TV = 32'h100;

    pc_ctrl_ras #(
        .PC_WIDTH  (32),
        .RESET_PC  (32'h0),
        .TRAP_VEC  (TV),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .go            (go),
        .trap          (trap),
        .mret          (mret),
        .branch_taken  (branch_taken),
        .call          (call),
        .ret           (ret),
        .branch_target (branch_target),
        .PC            (PC),
        .epc           (epc),
        .ras_count     (ras_count),
        .ras_hit       (ras_hit),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_push(input logic [31:0] v);
        m_ras.push_back(v);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
    endtask

    // One clock: apply inputs, advance the model, then compare all outputs
    task automatic step(input logic r, input logic g, input logic tp, input logic mr,
                        input logic bt, input logic cl, input logic rt, input logic [31:0] tgt);
        logic [31:0] ret_addr;
        rst_n = r; go = g; trap = tp; mret = mr;
        branch_taken = bt; call = cl; ret = rt; branch_target = tgt;
        @(posedge clk);
        ret_addr = m_pc + 32'd4;
        if (!r) begin
            m_pc = 32'h0; m_epc = 32'h0; m_hit = 0; m_mis = 0; m_ras.delete();
        end else if (!g) begin
            m_hit = 0; m_mis = 0;
        end else begin
            m_hit = 0; m_mis = 0;
            if (tp) begin
                m_epc = m_pc; m_pc = TV;
            end else if (mr) begin
                m_pc = m_epc;
            end else if (rt && m_ras.size() > 0) begin
                m_pc  = m_ras.pop_back();
                m_hit = 1;
                if (cl) model_push(ret_addr);
            end else if (rt || cl || bt) begin
                if (tgt % 4 != 0) begin
                    m_epc = m_pc; m_pc = TV; m_mis = 1;
                end else begin
                    if (cl) model_push(ret_addr);
                    m_pc = tgt;
                end
            end else begin
                m_pc = ret_addr;
            end
        end
        #1;
        chk("pc", PC, m_pc);
        chk("epc", epc, m_epc);
        chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
        chk("ras_hit", 32'(ras_hit), 32'(m_hit));
        chk("misaligned", 32'(misaligned), 32'(m_mis));
    endtask

    initial begin
        m_pc = 0; m_epc = 0; m_hit = 0; m_mis = 0;
        // 1: reset then sequential fetch
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("t1_reset_pc", PC, 32'h0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("t1_pc12", PC, 32'hC);
        // 2: wrap at top of address space
        step(1, 1, 0, 0, 1, 0, 0, 32'hFFFF_FFFC);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("t2_wrap", PC, 32'h0);
        // 3: single call/return
        step(1, 1, 0, 0, 1, 0, 0, 32'h40);
        step(1, 1, 0, 0, 0, 1, 0, 32'h200);
        chk("t3_call_pc", PC, 32'h200);
        chk("t3_count1", 32'(ras_count), 32'd1);
        step(1, 1, 0, 0, 0, 0, 1, 32'h300);
        chk("t3_ret_pc", PC, 32'h44);
        chk("t3_hit", 32'(ras_hit), 32'd1);
        // 4: overflow overwrites oldest, then drain to empty
        step(1, 1, 0, 0, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 0, 1, 0, 32'h10);
        step(1, 1, 0, 0, 0, 1, 0, 32'h20);
        step(1, 1, 0, 0, 0, 1, 0, 32'h30);
        step(1, 1, 0, 0, 0, 1, 0, 32'h40);
        step(1, 1, 0, 0, 0, 1, 0, 32'h500);
        chk("t4_full", 32'(ras_count), 32'd4);
        step(1, 1, 0, 0, 0, 0, 1, 32'h0);
        chk("t4_ret1", PC, 32'h44);
        step(1, 1, 0, 0, 0, 0, 1, 32'h0);
        chk("t4_ret2", PC, 32'h34);
        step(1, 1, 0, 0, 0, 0, 1, 32'h0);
        chk("t4_ret3", PC, 32'h24);
        step(1, 1, 0, 0, 0, 0, 1, 32'h0);
        chk("t4_ret4", PC, 32'h14);
        step(1, 1, 0, 0, 0, 0, 1, 32'h80);
        chk("t4_empty_ret", PC, 32'h80);
        chk("t4_no_hit", 32'(ras_hit), 32'd0);
        // 5: misaligned redirect traps, mret returns
        step(1, 1, 0, 0, 1, 0, 0, 32'h50);
        step(1, 1, 0, 0, 1, 0, 0, 32'h102);
        chk("t5_trap_pc", PC, TV);
        chk("t5_epc", epc, 32'h50);
        chk("t5_mis", 32'(misaligned), 32'd1);
        step(1, 1, 0, 1, 0, 0, 0, 32'h0);
        chk("t5_mret", PC, 32'h50);
        chk("t5_mis_clr", 32'(misaligned), 32'd0);
        // 6: trap beats call/branch, stall holds, reset wins
        step(1, 1, 0, 0, 0, 1, 0, 32'h60);
        step(1, 1, 1, 0, 1, 1, 0, 32'h200);
        chk("t6_trap_pc", PC, TV);
        chk("t6_epc", epc, 32'h60);
        chk("t6_count", 32'(ras_count), 32'd1);
        step(1, 0, 0, 0, 1, 1, 1, 32'h300);
        step(1, 0, 1, 0, 0, 0, 0, 32'h300);
        chk("t6_stall", PC, TV);
        step(0, 1, 0, 0, 0, 1, 0, 32'h400);
        chk("t6_rst_pc", PC, 32'h0);
        chk("t6_rst_cnt", 32'(ras_count), 32'd0);
        // Randomized traffic, call/ret heavy to exercise the stack
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = {$urandom_range(0, 255), 2'b00} & 32'h3FC;
            if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 49) != 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, t);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
